txwkram_frame_reader: RTL and testbench

- Read-side sequencer for the double-buffered TX work RAM.
- On each start request it reads bytes 0..RAMSIZE-1 of the read bank and streams them through a valid/ready byte interface to the host-link transmitter.
- It holds the RAM read-request line high for the whole frame, so a pending bank swap is deferred until the frame ends. Every frame is therefore one consistent snapshot.

---
 rtl/txwkram_frame_reader.sv | 166 ++++++++++++++++
 tb/tb_txwkram_frame_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txwkram_frame_reader.sv
// Read-side sequencer for the double-buffered TX work RAM: streams one
// consistent bank snapshot per start request over a valid/ready byte port.
//
// Parameters: RAMSIZE (1..127) bytes per frame.
// Ports:
//   i_CLK, i_RST           clock, async active-high reset
//   i_START, i_ABORT       frame request (IDLE only), abandon frame
//   o_BUSY                 high while a frame is in progress
//   o_R2_RD, o_R2_RD_INDEX work RAM read request / byte index
//   i_R2_DATA              work RAM data, one cycle after the request
//   o_TX_VALID/DATA/LAST   byte stream offered to the transmitter
//   i_TX_READY             transmitter accepts the offered byte
//   o_FRAME_DONE           one-cycle pulse after the final byte
//   o_FRAME_CNT            completed frame counter (wraps)
// Optional: define TXWKRAM_FRAME_CSUM_EN to append a checksum byte that
// makes the 8-bit sum of the whole frame zero.
module txwkram_frame_reader #(
  parameter int RAMSIZE = 47
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_START,
  input  logic       i_ABORT,
  output logic       o_BUSY,
  output logic       o_R2_RD,
  output logic [6:0] o_R2_RD_INDEX,
  input  logic [7:0] i_R2_DATA,
  output logic       o_TX_VALID,
  output logic [7:0] o_TX_DATA,
  output logic       o_TX_LAST,
  input  logic       i_TX_READY,
  output logic       o_FRAME_DONE,
  output logic [7:0] o_FRAME_CNT
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
`ifdef TXWKRAM_FRAME_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(RAMSIZE - 1);

  state_t     state;
  state_t     next;
  logic [6:0] idx;
  logic       hs;
  logic       is_last;
`ifdef TXWKRAM_FRAME_CSUM_EN
  logic [7:0] sum;
`endif

  assign hs      = o_TX_VALID & i_TX_READY;
  assign is_last = (idx == LAST_IDX);

  // The read request covers every busy state except DONE, so a pending
  // bank swap can only land in DONE/IDLE, between frames.
  assign o_BUSY        = (state != IDLE);
  assign o_R2_RD       = o_BUSY && (state != DONE);
  assign o_R2_RD_INDEX = idx;
  assign o_FRAME_DONE  = (state == DONE) && !i_ABORT;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    if (i_ABORT) begin
      next = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (i_START) next = FETCH;
        FETCH: next = LATCH;
        LATCH: next = SEND;
        SEND: begin
          if (hs) begin
            if (!is_last) next = FETCH;
`ifdef TXWKRAM_FRAME_CSUM_EN
            else          next = CSUM;
`else
            else          next = DONE;
`endif
          end
        end
`ifdef TXWKRAM_FRAME_CSUM_EN
        CSUM:  if (hs) next = DONE;
`endif
        DONE:  next = IDLE;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      idx         <= '0;
      o_TX_VALID  <= 1'b0;
      o_TX_DATA   <= '0;
      o_TX_LAST   <= 1'b0;
      o_FRAME_CNT <= '0;
`ifdef TXWKRAM_FRAME_CSUM_EN
      sum         <= '0;
`endif
    end else if (i_ABORT) begin
      o_TX_VALID <= 1'b0;
      o_TX_LAST  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_START) begin
            idx <= '0;
`ifdef TXWKRAM_FRAME_CSUM_EN
            sum <= '0;
`endif
          end
        end
        LATCH: begin
          o_TX_DATA  <= i_R2_DATA;
          o_TX_VALID <= 1'b1;
`ifdef TXWKRAM_FRAME_CSUM_EN
          o_TX_LAST  <= 1'b0;
`else
          o_TX_LAST  <= is_last;
`endif
        end
        SEND: begin
          if (hs) begin
`ifdef TXWKRAM_FRAME_CSUM_EN
            sum <= sum + o_TX_DATA;
            if (!is_last) begin
              idx        <= idx + 7'd1;
              o_TX_VALID <= 1'b0;
            end else begin
              // Checksum follows back-to-back; include the byte just sent.
              o_TX_DATA <= 8'd0 - (sum + o_TX_DATA);
              o_TX_LAST <= 1'b1;
            end
`else
            if (!is_last) idx <= idx + 7'd1;
            o_TX_VALID <= 1'b0;
            o_TX_LAST  <= 1'b0;
`endif
          end
        end
`ifdef TXWKRAM_FRAME_CSUM_EN
        CSUM: begin
          if (hs) begin
            o_TX_VALID <= 1'b0;
            o_TX_LAST  <= 1'b0;
          end
        end
`endif
        DONE: o_FRAME_CNT <= o_FRAME_CNT + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_txwkram_frame_reader.sv
// Bench for txwkram_frame_reader: two-bank work RAM model, frame-level
// scoreboard checked every cycle, plus directed literal expectations.
module tb_txwkram_frame_reader;

  localparam int RS = 47;
`ifdef TXWKRAM_FRAME_CSUM_EN
  localparam int FL = RS + 1;
`else
  localparam int FL = RS;
`endif

  logic       clk;
  logic       i_RST, i_START, i_ABORT, i_TX_READY;
  logic [7:0] i_R2_DATA;
  logic       o_BUSY, o_R2_RD, o_TX_VALID, o_TX_LAST, o_FRAME_DONE;
  logic [6:0] o_R2_RD_INDEX;
  logic [7:0] o_TX_DATA, o_FRAME_CNT;

  txwkram_frame_reader #(.RAMSIZE(RS)) dut (
    .i_CLK(clk), .i_RST(i_RST), .i_START(i_START), .i_ABORT(i_ABORT),
    .o_BUSY(o_BUSY), .o_R2_RD(o_R2_RD), .o_R2_RD_INDEX(o_R2_RD_INDEX),
    .i_R2_DATA(i_R2_DATA), .o_TX_VALID(o_TX_VALID), .o_TX_DATA(o_TX_DATA),
    .o_TX_LAST(o_TX_LAST), .i_TX_READY(i_TX_READY),
    .o_FRAME_DONE(o_FRAME_DONE), .o_FRAME_CNT(o_FRAME_CNT)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Work RAM: synchronous read, bank swap only while read request is low.
  logic [7:0] bank [2][128];
  bit rb = 0;
  int swap_reqs = 0;
  int swaps_done = 0;
  always @(posedge clk) begin
    if (o_R2_RD) i_R2_DATA <= bank[rb][o_R2_RD_INDEX];
    if (swap_reqs != swaps_done && !o_R2_RD) begin
      rb <= ~rb;
      swaps_done <= swaps_done + 1;
    end
  end

  int nchk = 0;
  int npass = 0;

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Ready driver: 0 low, 1 high, 2 random with 20-cycle stalls.
  int rmode = 1;
  initial begin
    int stall;
    stall = 0;
    i_TX_READY = 1;
    forever begin
      @(posedge clk); #2;
      case (rmode)
        0: i_TX_READY = 0;
        1: i_TX_READY = 1;
        default: begin
          if (stall > 0) begin
            i_TX_READY = 0;
            stall--;
          end else if ($urandom_range(0, 15) == 0) begin
            stall = 20;
            i_TX_READY = 0;
          end else begin
            i_TX_READY = 1'($urandom_range(0, 1));
          end
        end
      endcase
    end
  end

  // Frame-level model: expected byte queue built from the bank snapshot
  // at the accepted start; state is just "frame active" / "done due".
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  logic [7:0] rx_d[$];
  bit         rx_l[$];
  int         rx_c[$];
  bit   active = 0, done_due = 0;
  int   cnt_m = 0, nframes = 0, start_neg = 0;
  bit   prev_v = 0, prev_r = 0, prev_a = 0, prev_l = 0;
  logic [7:0] prev_d = 0;

  initial begin
    bit idle_now, b;
    logic [7:0] s, d;
    bit l;
    forever begin
      @(negedge clk);
      if (i_RST) begin
        exp_d.delete(); exp_l.delete();
        active = 0; done_due = 0; cnt_m = 0; prev_v = 0;
        continue;
      end
      idle_now = !active && !done_due;
      check(o_FRAME_DONE == done_due, "frame_done", o_FRAME_DONE, done_due);
      check(o_FRAME_CNT == 8'(cnt_m), "frame_cnt", o_FRAME_CNT, cnt_m & 255);
      check(o_BUSY == (active || done_due), "busy", o_BUSY, active || done_due);
      check(o_R2_RD == active, "r2_rd", o_R2_RD, active);
      if (prev_v && !prev_r && !prev_a) begin
        check(o_TX_VALID == 1, "stall_valid", o_TX_VALID, 1);
        check(o_TX_DATA == prev_d, "stall_data", o_TX_DATA, prev_d);
        check(o_TX_LAST == prev_l, "stall_last", o_TX_LAST, prev_l);
      end
      if (done_due) begin
        cnt_m++;
        nframes++;
        done_due = 0;
      end
      if (i_ABORT) begin
        exp_d.delete(); exp_l.delete();
        active = 0;
      end else if (o_TX_VALID && i_TX_READY) begin
        if (exp_d.size() == 0) begin
          check(0, "unexpected_byte", o_TX_DATA, 0);
        end else begin
          d = exp_d.pop_front();
          l = exp_l.pop_front();
          check(o_TX_DATA == d, "tx_data", o_TX_DATA, d);
          check(o_TX_LAST == l, "tx_last", o_TX_LAST, l);
          rx_d.push_back(o_TX_DATA);
          rx_l.push_back(o_TX_LAST);
          rx_c.push_back(cyc);
          if (l) begin
            active = 0;
            done_due = 1;
          end
        end
      end
      if (idle_now && i_START && !i_ABORT) begin
        b = (swap_reqs != swaps_done) ? ~rb : rb;
        s = 0;
        rx_d.delete(); rx_l.delete(); rx_c.delete();
        for (int i = 0; i < RS; i++) begin
          exp_d.push_back(bank[b][i]);
          s = s + bank[b][i];
`ifdef TXWKRAM_FRAME_CSUM_EN
          exp_l.push_back(0);
`else
          exp_l.push_back(i == RS - 1);
`endif
        end
`ifdef TXWKRAM_FRAME_CSUM_EN
        exp_d.push_back(8'd0 - s);
        exp_l.push_back(1);
`endif
        active = 1;
        start_neg = cyc;
      end
      prev_v = o_TX_VALID; prev_r = i_TX_READY; prev_a = i_ABORT;
      prev_d = o_TX_DATA;  prev_l = o_TX_LAST;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 i_START = 1;
    @(posedge clk); #1 i_START = 0;
  endtask

  task automatic wait_frame(input int budget, input string nm);
    int tgt = nframes + 1;
    int n = 0;
    while (nframes < tgt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(nframes >= tgt, nm, nframes, tgt);
  endtask

  task automatic wait_rx(input int cnt, input int budget, input string nm);
    int n = 0;
    while (rx_d.size() < cnt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(rx_d.size() >= cnt, nm, rx_d.size(), cnt);
  endtask

  initial begin
    int n, cnt_save;
    for (int i = 0; i < 128; i++) begin
      bank[0][i] = 8'(i + 1);
      bank[1][i] = 8'(8'h80 + i);
    end
    i_RST = 1; i_START = 0; i_ABORT = 0;
    repeat (3) @(posedge clk);
    #1;
    check(o_BUSY == 0 && o_R2_RD == 0 && o_FRAME_DONE == 0,
          "reset_ctl", {o_BUSY, o_R2_RD, o_FRAME_DONE}, 0);
    check(o_TX_VALID == 0 && o_TX_LAST == 0, "reset_tx",
          {o_TX_VALID, o_TX_LAST}, 0);
    check(o_R2_RD_INDEX == 0 && o_TX_DATA == 0 && o_FRAME_CNT == 0,
          "reset_regs", o_TX_DATA, 0);
    @(posedge clk); #1 i_RST = 0;

    // Basic frame, ready held high.
    rmode = 1;
    pulse_start();
    wait_frame(400, "t1_timeout");
    check(rx_d.size() == FL, "t1_len", rx_d.size(), FL);
    check(rx_d[0] == 8'h01, "t1_first", rx_d[0], 8'h01);
    check(rx_d[46] == 8'h2F, "t1_byte46", rx_d[46], 8'h2F);
    check(rx_l[45] == 0, "t1_last45", rx_l[45], 0);
`ifndef TXWKRAM_FRAME_CSUM_EN
    check(rx_l[46] == 1, "t1_last46", rx_l[46], 1);
`endif
    check(rx_c[0] - start_neg == 3, "t1_latency", rx_c[0] - start_neg, 3);
    check(rx_c[46] - start_neg == 141, "t1_span", rx_c[46] - start_neg, 141);
    @(posedge clk); #1;
    check(o_FRAME_CNT == 1, "t1_cnt", o_FRAME_CNT, 1);

    // Random ready with long stalls, starts while busy are ignored.
    rmode = 2;
    pulse_start();
    wait_rx(8, 2000, "t2_rx8");
    pulse_start();
    wait_rx(20, 2000, "t2_rx20");
    pulse_start();
    wait_frame(4000, "t2_timeout");
    check(rx_d.size() == FL, "t2_len", rx_d.size(), FL);
    repeat (30) @(posedge clk);
    #1;
    check(o_BUSY == 0 && o_FRAME_CNT == 2, "t2_no_extra", o_FRAME_CNT, 2);

    // Bank swap requested mid-frame lands between frames.
    rmode = 1;
    pulse_start();
    wait_rx(10, 200, "t3_rx10");
    swap_reqs++;
    wait_frame(400, "t3_timeout");
    check(rx_d[46] == 8'h2F, "t3_old_bank", rx_d[46], 8'h2F);
    pulse_start();
    wait_frame(400, "t3b_timeout");
    check(rx_d[0] == 8'h80, "t3_new_first", rx_d[0], 8'h80);
    check(rx_d[46] == 8'hAE, "t3_new_byte46", rx_d[46], 8'hAE);
    check(swaps_done == 1, "t3_swaps", swaps_done, 1);

    // Abort while byte 5 is stalled in SEND.
    pulse_start();
    wait_rx(5, 200, "t4_rx5");
    rmode = 0;
    n = 0;
    while (!o_TX_VALID && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(o_TX_VALID == 1, "t4_valid", o_TX_VALID, 1);
    check(o_TX_DATA == 8'h85, "t4_byte5", o_TX_DATA, 8'h85);
    cnt_save = o_FRAME_CNT;
    i_ABORT = 1;
    @(posedge clk); #1 i_ABORT = 0;
    check(o_BUSY == 0 && o_TX_VALID == 0 && o_R2_RD == 0, "t4_idle",
          {o_BUSY, o_TX_VALID, o_R2_RD}, 0);
    repeat (5) @(posedge clk);
    #1;
    check(o_FRAME_CNT == 8'(cnt_save), "t4_cnt", o_FRAME_CNT, cnt_save);
    rmode = 1;
    pulse_start();
    wait_frame(400, "t4_timeout");
    check(rx_d[0] == 8'h80 && rx_d.size() == FL, "t4_restart", rx_d[0], 8'h80);

    // Async reset mid-frame.
    rmode = 2;
    pulse_start();
    wait_rx(8, 2000, "t5_rx8");
    pulse_start();
    wait_rx(12, 2000, "t5_rx12");
    @(posedge clk); #3 i_RST = 1;
    #1;
    check(o_TX_VALID == 0 && o_BUSY == 0 && o_R2_RD == 0, "t5_rst_ctl",
          {o_TX_VALID, o_BUSY, o_R2_RD}, 0);
    check(o_FRAME_CNT == 0 && o_TX_DATA == 0 && o_R2_RD_INDEX == 0,
          "t5_rst_regs", o_FRAME_CNT, 0);
    @(posedge clk); #1 i_RST = 0;
    rmode = 1;
    pulse_start();
    wait_frame(400, "t5_timeout");
    @(posedge clk); #1;
    check(o_FRAME_CNT == 1, "t5_cnt", o_FRAME_CNT, 1);

    // All-ones frame: checksum byte / last-byte placement.
    for (int i = 0; i < 128; i++) bank[rb][i] = 8'h01;
    pulse_start();
    wait_frame(400, "t6_timeout");
    check(rx_d.size() == FL, "t6_len", rx_d.size(), FL);
`ifdef TXWKRAM_FRAME_CSUM_EN
    check(rx_d[47] == 8'hD1, "t6_csum", rx_d[47], 8'hD1);
    check(rx_l[47] == 1 && rx_l[46] == 0, "t6_csum_last", rx_l[47], 1);
`else
    check(rx_d[46] == 8'h01 && rx_l[46] == 1, "t6_last", rx_l[46], 1);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
